// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: two-requester arbiter and sequencer in front of a single-port DataMemory.
//
// Port 0 (pipeline MEM stage) has fixed priority over port 1 (loader/DMA/debug). Two
// mechanisms bound that priority:
//   - a starvation counter forces a port-1 grant after STARVE_LIMIT denied cycles;
//   - a short burst lock lets port 1 keep up to BURST_MAX back-to-back grants.
// One word access is granted per cycle. Read data is registered and returned one cycle
// after the read grant, together with a one-cycle valid strobe.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   p0Req/p0Write/p0Addr/p0WData   port-0 request, direction, byte address, write data
//   p0Gnt                       combinational grant for port 0
//   p0Valid/p0RData             registered read-return strobe and data for port 0
//   p1*                         as port 0, plus p1Lock (burst lock request)
//   memAddr/memWriteData/memRead/memWrite   DataMemory drive from the granted port
//   memReadData                 combinational DataMemory read data
//   stallMem                    pipeline stall: p0 requesting but not granted
//   accessErr                   registered pulse: previous granted word index >= DEPTH
module dm_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned BURST_MAX    = 4,
  parameter int unsigned DEPTH        = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p0Req,
  input  logic        p0Write,
  input  logic [31:0] p0Addr,
  input  logic [31:0] p0WData,
  output logic        p0Gnt,
  output logic        p0Valid,
  output logic [31:0] p0RData,
  input  logic        p1Req,
  input  logic        p1Write,
  input  logic        p1Lock,
  input  logic [31:0] p1Addr,
  input  logic [31:0] p1WData,
  output logic        p1Gnt,
  output logic        p1Valid,
  output logic [31:0] p1RData,
  output logic [31:0] memAddr,
  output logic [31:0] memWriteData,
  output logic        memRead,
  output logic        memWrite,
  input  logic [31:0] memReadData,
  output logic        stallMem,
  output logic        accessErr
);

  localparam int unsigned WaitW  = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned BurstW = $clog2(BURST_MAX + 1);
  localparam logic [WaitW-1:0]  WaitMax  = WaitW'(STARVE_LIMIT);
  localparam logic [BurstW-1:0] BurstMax = BurstW'(BURST_MAX);

  typedef enum logic [0:0] {StIdle, StLock1} state_e;

  state_e              state_q;
  logic [WaitW-1:0]    wait_cnt_q;
  logic [BurstW-1:0]   burst_cnt_q;
  logic                p0_valid_q, p1_valid_q;
  logic [31:0]         p0_rdata_q, p1_rdata_q;
  logic                access_err_q;

  logic        lock_hold;    // locked burst continues
  logic        starved;      // port 1 has waited long enough
  logic        gnt0, gnt1;
  logic [31:0] word_idx;
  logic        addr_err;

  assign lock_hold = (state_q == StLock1) && p1Req && p1Lock && (burst_cnt_q < BurstMax);
  assign starved   = p1Req && (wait_cnt_q == WaitMax);

  // Priority: lock, starvation, port 0, port 1. Nothing is granted while in reset.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      if (lock_hold || starved) begin
        gnt1 = 1'b1;
      end else if (p0Req) begin
        gnt0 = 1'b1;
      end else if (p1Req) begin
        gnt1 = 1'b1;
      end
    end
  end

  always_comb begin
    memAddr      = 32'h0;
    memWriteData = 32'h0;
    memRead      = 1'b0;
    memWrite     = 1'b0;
    if (gnt0) begin
      memAddr      = p0Addr;
      memWriteData = p0WData;
      memRead      = ~p0Write;
      memWrite     = p0Write;
    end else if (gnt1) begin
      memAddr      = p1Addr;
      memWriteData = p1WData;
      memRead      = ~p1Write;
      memWrite     = p1Write;
    end
  end

  assign word_idx = {2'b00, memAddr[31:2]};
  assign addr_err = (gnt0 || gnt1) && (word_idx >= DEPTH);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      wait_cnt_q   <= '0;
      burst_cnt_q  <= '0;
      p0_valid_q   <= 1'b0;
      p1_valid_q   <= 1'b0;
      p0_rdata_q   <= 32'h0;
      p1_rdata_q   <= 32'h0;
      access_err_q <= 1'b0;
    end else begin
      p0_valid_q   <= gnt0 && !p0Write;
      p1_valid_q   <= gnt1 && !p1Write;
      access_err_q <= addr_err;
      if (gnt0 && !p0Write) p0_rdata_q <= memReadData;
      if (gnt1 && !p1Write) p1_rdata_q <= memReadData;

      if (!p1Req || gnt1) begin
        wait_cnt_q <= '0;
      end else if (wait_cnt_q < WaitMax) begin
        wait_cnt_q <= wait_cnt_q + WaitW'(1);
      end

      unique case (state_q)
        StIdle: begin
          if (gnt1 && p1Lock) begin
            state_q     <= StLock1;
            burst_cnt_q <= BurstW'(1);
          end
        end
        StLock1: begin
          // lock_hold implies a port-1 grant with burst_cnt_q below the cap.
          if (lock_hold) begin
            burst_cnt_q <= burst_cnt_q + BurstW'(1);
          end else begin
            state_q     <= StIdle;
            burst_cnt_q <= '0;
          end
        end
        default: begin
          state_q     <= StIdle;
          burst_cnt_q <= '0;
        end
      endcase
    end
  end

  // Valid is masked by reset so an access interrupted by reset never returns a strobe.
  assign p0Valid   = p0_valid_q & rst_n;
  assign p1Valid   = p1_valid_q & rst_n;
  assign p0RData   = p0_rdata_q;
  assign p1RData   = p1_rdata_q;
  assign p0Gnt     = gnt0;
  assign p1Gnt     = gnt1;
  assign stallMem  = p0Req & ~gnt0;
  assign accessErr = access_err_q;

endmodule

// File: tb/tb_dm_port_arbiter.sv
module tb_dm_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p0Req, p0Write, p1Req, p1Write, p1Lock;
  logic [31:0] p0Addr, p0WData, p1Addr, p1WData;
  logic        p0Gnt, p0Valid, p1Gnt, p1Valid;
  logic [31:0] p0RData, p1RData;
  logic [31:0] memAddr, memWriteData, memReadData;
  logic        memRead, memWrite, stallMem, accessErr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dm_port_arbiter #(
    .STARVE_LIMIT(4),
    .BURST_MAX   (4),
    .DEPTH       (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .p0Req       (p0Req),
    .p0Write     (p0Write),
    .p0Addr      (p0Addr),
    .p0WData     (p0WData),
    .p0Gnt       (p0Gnt),
    .p0Valid     (p0Valid),
    .p0RData     (p0RData),
    .p1Req       (p1Req),
    .p1Write     (p1Write),
    .p1Lock      (p1Lock),
    .p1Addr      (p1Addr),
    .p1WData     (p1WData),
    .p1Gnt       (p1Gnt),
    .p1Valid     (p1Valid),
    .p1RData     (p1RData),
    .memAddr     (memAddr),
    .memWriteData(memWriteData),
    .memRead     (memRead),
    .memWrite    (memWrite),
    .memReadData (memReadData),
    .stallMem    (stallMem),
    .accessErr   (accessErr)
  );

  // DataMemory stand-in: 16 words so out-of-range index 8 still lands somewhere harmless.
  logic [31:0] mem [16];
  assign memReadData = mem[memAddr[5:2]];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
    end else if (memWrite) begin
      mem[memAddr[5:2]] <= memWriteData;
    end
  end

  typedef struct {
    logic        rst_n;
    logic        r0, w0;
    logic [31:0] a0, d0;
    logic        r1, w1, l1;
    logic [31:0] a1, d1;
    logic        g0, g1, st, mr, mw, v0, v1, er;
    logic [31:0] rd0, rd1;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(int rst, int r0, int w0, bit [31:0] a0, bit [31:0] d0,
                              int r1, int w1, int l1, bit [31:0] a1, bit [31:0] d1,
                              int g0, int g1, int st, int mr, int mw,
                              int v0, int v1, int er, bit [31:0] rd0, bit [31:0] rd1);
    vec_t v;
    v.rst_n = 1'(rst);
    v.r0 = 1'(r0); v.w0 = 1'(w0); v.a0 = a0; v.d0 = d0;
    v.r1 = 1'(r1); v.w1 = 1'(w1); v.l1 = 1'(l1); v.a1 = a1; v.d1 = d1;
    v.g0 = 1'(g0); v.g1 = 1'(g1); v.st = 1'(st); v.mr = 1'(mr); v.mw = 1'(mw);
    v.v0 = 1'(v0); v.v1 = 1'(v1); v.er = 1'(er); v.rd0 = rd0; v.rd1 = rd1;
    tbl.push_back(v);
  endfunction

  task automatic chk(string name, int row, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    rst_n   = v.rst_n;
    p0Req   = v.r0; p0Write = v.w0; p0Addr = v.a0; p0WData = v.d0;
    p1Req   = v.r1; p1Write = v.w1; p1Lock = v.l1; p1Addr = v.a1; p1WData = v.d1;
  endtask

  localparam logic [31:0] DB = 32'hDEADBEEF;

  function automatic bit [31:0] bd(int i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  function automatic bit [31:0] ba(int i);
    return 32'(4 * (i + 1));
  endfunction

  initial begin
    logic [31:0] exp_addr, exp_wdata;

    // Reset held 3 cycles with both ports requesting.
    add(0, 1,0,0,0,     1,0,0,4,0,  0,0,1,0,0, 0,0,0, 0,0);
    add(0, 1,0,0,0,     1,0,0,4,0,  0,0,1,0,0, 0,0,0, 0,0);
    add(0, 1,0,0,0,     1,0,0,4,0,  0,0,1,0,0, 0,0,0, 0,0);
    // p1 writes DEADBEEF at 0x4, p0 reads it back.
    add(1, 0,0,0,0,     1,1,0,4,DB, 0,1,0,0,1, 0,0,0, 0,0);
    add(1, 1,0,4,0,     0,0,0,0,0,  1,0,0,1,0, 0,0,0, 0,0);
    add(1, 0,0,0,0,     0,0,0,0,0,  0,0,0,0,0, 1,0,0, DB,0);
    // Both reading, no lock: 4 x p0 then starved p1, repeating.
    add(1, 1,0,0,0,     1,0,0,4,0,  1,0,0,1,0, 0,0,0, DB,0);
    add(1, 1,0,0,0,     1,0,0,4,0,  1,0,0,1,0, 1,0,0, 0,0);
    add(1, 1,0,0,0,     1,0,0,4,0,  1,0,0,1,0, 1,0,0, 0,0);
    add(1, 1,0,0,0,     1,0,0,4,0,  1,0,0,1,0, 1,0,0, 0,0);
    add(1, 1,0,0,0,     1,0,0,4,0,  0,1,1,1,0, 1,0,0, 0,0);
    add(1, 1,0,0,0,     1,0,0,4,0,  1,0,0,1,0, 0,1,0, 0,DB);
    add(1, 1,0,0,0,     1,0,0,4,0,  1,0,0,1,0, 1,0,0, 0,DB);
    add(1, 1,0,0,0,     1,0,0,4,0,  1,0,0,1,0, 1,0,0, 0,DB);
    add(1, 1,0,0,0,     1,0,0,4,0,  1,0,0,1,0, 1,0,0, 0,DB);
    add(1, 1,0,0,0,     1,0,0,4,0,  0,1,1,1,0, 1,0,0, 0,DB);
    // Locked 6-beat write burst against constant p0 reads.
    add(1, 1,0,0,0, 1,1,1,ba(1),bd(1), 1,0,0,1,0, 0,1,0, 0,DB);
    add(1, 1,0,0,0, 1,1,1,ba(1),bd(1), 1,0,0,1,0, 1,0,0, 0,DB);
    add(1, 1,0,0,0, 1,1,1,ba(1),bd(1), 1,0,0,1,0, 1,0,0, 0,DB);
    add(1, 1,0,0,0, 1,1,1,ba(1),bd(1), 1,0,0,1,0, 1,0,0, 0,DB);
    add(1, 1,0,0,0, 1,1,1,ba(1),bd(1), 0,1,1,0,1, 1,0,0, 0,DB);
    add(1, 1,0,0,0, 1,1,1,ba(2),bd(2), 0,1,1,0,1, 0,0,0, 0,DB);
    add(1, 1,0,0,0, 1,1,1,ba(3),bd(3), 0,1,1,0,1, 0,0,0, 0,DB);
    add(1, 1,0,0,0, 1,1,1,ba(4),bd(4), 0,1,1,0,1, 0,0,0, 0,DB);
    add(1, 1,0,0,0, 1,1,1,ba(5),bd(5), 1,0,0,1,0, 0,0,0, 0,DB);
    add(1, 1,0,0,0, 1,1,1,ba(5),bd(5), 1,0,0,1,0, 1,0,0, 0,DB);
    add(1, 1,0,0,0, 1,1,1,ba(5),bd(5), 1,0,0,1,0, 1,0,0, 0,DB);
    add(1, 1,0,0,0, 1,1,1,ba(5),bd(5), 1,0,0,1,0, 1,0,0, 0,DB);
    add(1, 1,0,0,0, 1,1,1,ba(5),bd(5), 0,1,1,0,1, 1,0,0, 0,DB);
    add(1, 1,0,0,0, 1,1,1,ba(6),bd(6), 0,1,1,0,1, 0,0,0, 0,DB);
    add(1, 1,0,0,0,     0,0,0,0,0,  1,0,0,1,0, 0,0,0, 0,DB);
    add(1, 0,0,0,0,     0,0,0,0,0,  0,0,0,0,0, 1,0,0, 0,DB);
    // Read back all six burst words through port 0.
    add(1, 1,0,ba(1),0, 0,0,0,0,0,  1,0,0,1,0, 0,0,0, 0,DB);
    add(1, 1,0,ba(2),0, 0,0,0,0,0,  1,0,0,1,0, 1,0,0, bd(1),DB);
    add(1, 1,0,ba(3),0, 0,0,0,0,0,  1,0,0,1,0, 1,0,0, bd(2),DB);
    add(1, 1,0,ba(4),0, 0,0,0,0,0,  1,0,0,1,0, 1,0,0, bd(3),DB);
    add(1, 1,0,ba(5),0, 0,0,0,0,0,  1,0,0,1,0, 1,0,0, bd(4),DB);
    add(1, 1,0,ba(6),0, 0,0,0,0,0,  1,0,0,1,0, 1,0,0, bd(5),DB);
    add(1, 0,0,0,0,     0,0,0,0,0,  0,0,0,0,0, 1,0,0, bd(6),DB);
    // Out-of-range write (index 8) pulses accessErr; index 7 read does not.
    add(1, 1,1,32'h20,32'h55, 0,0,0,0,0, 1,0,0,0,1, 0,0,0, bd(6),DB);
    add(1, 0,0,0,0,     0,0,0,0,0,  0,0,0,0,0, 0,0,1, bd(6),DB);
    add(1, 0,0,0,0,     1,0,0,ba(6),0, 0,1,0,1,0, 0,0,0, bd(6),DB);
    add(1, 0,0,0,0,     0,0,0,0,0,  0,0,0,0,0, 0,1,0, bd(6),bd(6));

    rst_n = 1'b0;
    p0Req = 1'b0; p0Write = 1'b0; p0Addr = '0; p0WData = '0;
    p1Req = 1'b0; p1Write = 1'b0; p1Lock = 1'b0; p1Addr = '0; p1WData = '0;
    @(posedge clk);

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      exp_addr  = tbl[i].g0 ? tbl[i].a0 : (tbl[i].g1 ? tbl[i].a1 : 32'h0);
      exp_wdata = tbl[i].g0 ? tbl[i].d0 : (tbl[i].g1 ? tbl[i].d1 : 32'h0);
      chk("p0Gnt",        i, 32'(p0Gnt),     32'(tbl[i].g0));
      chk("p1Gnt",        i, 32'(p1Gnt),     32'(tbl[i].g1));
      chk("stallMem",     i, 32'(stallMem),  32'(tbl[i].st));
      chk("memRead",      i, 32'(memRead),   32'(tbl[i].mr));
      chk("memWrite",     i, 32'(memWrite),  32'(tbl[i].mw));
      chk("memAddr",      i, memAddr,        exp_addr);
      chk("memWriteData", i, memWriteData,   exp_wdata);
      chk("p0Valid",      i, 32'(p0Valid),   32'(tbl[i].v0));
      chk("p1Valid",      i, 32'(p1Valid),   32'(tbl[i].v1));
      chk("accessErr",    i, 32'(accessErr), 32'(tbl[i].er));
      chk("p0RData",      i, p0RData,        tbl[i].rd0);
      chk("p1RData",      i, p1RData,        tbl[i].rd1);
    end

    // Reset lands in the cycle after a locked p1 read grant.
    @(negedge clk);
    rst_n = 1'b1; p0Req = 1'b0; p1Req = 1'b1; p1Write = 1'b0; p1Lock = 1'b1; p1Addr = 32'h4;
    #1;
    chk("rstseq_p1Gnt", 0, 32'(p1Gnt), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstseq_p1Valid", 1, 32'(p1Valid), 32'd0);
    chk("rstseq_p1Gnt",   1, 32'(p1Gnt),   32'd0);
    chk("rstseq_memRead", 1, 32'(memRead), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; p0Req = 1'b1; p0Write = 1'b0; p0Addr = 32'h0;
    #1;
    // Lock must not survive reset: p0 wins over the still-locked p1.
    chk("rstseq_p0Gnt",   2, 32'(p0Gnt),   32'd1);
    chk("rstseq_p1Gnt",   2, 32'(p1Gnt),   32'd0);
    chk("rstseq_p1Valid", 2, 32'(p1Valid), 32'd0);
    chk("rstseq_p1RData", 2, p1RData,      32'h0);
    @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
